// File: rtl/fix_session_tx_arbiter_if.sv
// Bundle of the per-session TX request signals and the shared TX FIFO
// write path around fix_session_tx_arbiter.
//
//   req_i, connected_i, byte_i, byte_valid_i, eom_i : session -> arbiter
//   tx_ready_i                                      : FIFO    -> arbiter
//   gnt_o, byte_ready_o                             : arbiter -> session
//   send_message_valid_o, message_o, message_last_o,
//   message_host_o, abort_o, abort_host_o           : arbiter -> FIFO
//
// modport master : the session/FIFO side that drives requests and ready.
// modport slave  : the arbiter itself.
interface fix_session_tx_arbiter_if #(
    parameter int NUM_SESS = 4,
    parameter int DATA_W   = 8
);
    localparam int HW = $clog2(NUM_SESS);

    logic [NUM_SESS-1:0]        req_i;
    logic [NUM_SESS-1:0]        connected_i;
    logic [NUM_SESS*DATA_W-1:0] byte_i;
    logic [NUM_SESS-1:0]        byte_valid_i;
    logic [NUM_SESS-1:0]        eom_i;
    logic                       tx_ready_i;
    logic [NUM_SESS-1:0]        gnt_o;
    logic [NUM_SESS-1:0]        byte_ready_o;
    logic                       send_message_valid_o;
    logic [DATA_W-1:0]          message_o;
    logic                       message_last_o;
    logic [HW-1:0]              message_host_o;
    logic                       abort_o;
    logic [HW-1:0]              abort_host_o;

    modport master (
        output req_i, connected_i, byte_i, byte_valid_i, eom_i, tx_ready_i,
        input  gnt_o, byte_ready_o, send_message_valid_o, message_o,
               message_last_o, message_host_o, abort_o, abort_host_o
    );

    modport slave (
        input  req_i, connected_i, byte_i, byte_valid_i, eom_i, tx_ready_i,
        output gnt_o, byte_ready_o, send_message_valid_o, message_o,
               message_last_o, message_host_o, abort_o, abort_host_o
    );
endinterface

// File: rtl/fix_session_tx_arbiter.sv
// Shares the single byte-wide outbound path to the TOE TX FIFO among
// NUM_SESS sessions. Round-robin grants whole messages, holds the grant
// until end-of-message, ignores sessions without a live connection, and
// aborts the granted message on a stall timeout or host disconnect.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-low
//   bus  : fix_session_tx_arbiter_if.slave (session requests/bytes in,
//          grant/byte_ready out, FIFO write stream and abort out)
module fix_session_tx_arbiter #(
    parameter int NUM_SESS    = 4,
    parameter int DATA_W      = 8,
    parameter int STALL_LIMIT = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    fix_session_tx_arbiter_if.slave bus
);
    localparam int HW = $clog2(NUM_SESS);
    localparam int CW = $clog2(STALL_LIMIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    localparam logic [CW-1:0] STALL_MAX = CW'(STALL_LIMIT - 1);

    logic [1:0]          state_q, state_d;
    logic [NUM_SESS-1:0] gnt_q, gnt_d;
    logic [HW-1:0]       gidx_q, gidx_d;
    logic [HW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       stall_q, stall_d;
    logic                vld_q, vld_d;
    logic [DATA_W-1:0]   msg_q, msg_d;
    logic                last_q, last_d;
    logic [HW-1:0]       host_q, host_d;
    logic                abort_q, abort_d;
    logic [HW-1:0]       abort_host_q, abort_host_d;

    logic [NUM_SESS-1:0] elig;
    logic                win_found;
    logic [HW-1:0]       win_idx;
    logic [HW-1:0]       cand;
    logic                hs;
    logic [NUM_SESS-1:0] byte_ready;
    logic [DATA_W-1:0]   sess_byte [NUM_SESS];

    assign elig = bus.req_i & bus.connected_i;

    always_comb begin
        for (int s = 0; s < NUM_SESS; s++) begin
            sess_byte[s] = bus.byte_i[s*DATA_W +: DATA_W];
        end
    end

    // Round-robin search starts just after the last winner and wraps, so
    // the last winner has lowest priority next time.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 1; i <= NUM_SESS; i++) begin
            cand = HW'((int'(ptr_q) + i) % NUM_SESS);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // gnt_q is only non-zero in XFER, so no byte is ever accepted in
    // IDLE or ABORT. A disconnected host can never handshake.
    assign hs = gnt_q[gidx_q] & bus.byte_valid_i[gidx_q] & bus.tx_ready_i
              & bus.connected_i[gidx_q];

    always_comb begin
        byte_ready = '0;
        if (hs) begin
            byte_ready[gidx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gidx_d       = gidx_q;
        ptr_d        = ptr_q;
        stall_d      = stall_q;
        vld_d        = 1'b0;
        msg_d        = msg_q;
        last_d       = last_q;
        host_d       = host_q;
        abort_d      = 1'b0;
        abort_host_d = abort_host_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d          = ST_XFER;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    gidx_d           = win_idx;
                    ptr_d            = win_idx;
                    stall_d          = '0;
                end
            end
            ST_XFER: begin
                // A handshake takes precedence over disconnect and stall
                // expiry, so a completing eom byte never turns into an abort.
                if (hs) begin
                    vld_d   = 1'b1;
                    msg_d   = sess_byte[gidx_q];
                    last_d  = bus.eom_i[gidx_q];
                    host_d  = gidx_q;
                    stall_d = '0;
                    if (bus.eom_i[gidx_q]) begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (!bus.connected_i[gidx_q] || stall_q == STALL_MAX) begin
                    state_d      = ST_ABORT;
                    gnt_d        = '0;
                    abort_d      = 1'b1;
                    abort_host_d = gidx_q;
                    stall_d      = '0;
                end else begin
                    // Never reaches past STALL_MAX: that value aborts above.
                    stall_d = stall_q + 1'b1;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            gidx_q       <= '0;
            ptr_q        <= HW'(NUM_SESS - 1);
            stall_q      <= '0;
            vld_q        <= 1'b0;
            msg_q        <= '0;
            last_q       <= 1'b0;
            host_q       <= '0;
            abort_q      <= 1'b0;
            abort_host_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gidx_q       <= gidx_d;
            ptr_q        <= ptr_d;
            stall_q      <= stall_d;
            vld_q        <= vld_d;
            msg_q        <= msg_d;
            last_q       <= last_d;
            host_q       <= host_d;
            abort_q      <= abort_d;
            abort_host_q <= abort_host_d;
        end
    end

    assign bus.gnt_o                = gnt_q;
    assign bus.byte_ready_o         = byte_ready;
    assign bus.send_message_valid_o = vld_q;
    assign bus.message_o            = msg_q;
    assign bus.message_last_o       = last_q;
    assign bus.message_host_o       = host_q;
    assign bus.abort_o              = abort_q;
    assign bus.abort_host_o         = abort_host_q;
endmodule

// File: tb/tb_fix_session_tx_arbiter.sv
module tb_fix_session_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SL = 256;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    fix_session_tx_arbiter_if #(.NUM_SESS(N), .DATA_W(DW)) bus ();

    fix_session_tx_arbiter #(.NUM_SESS(N), .DATA_W(DW), .STALL_LIMIT(SL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: owner of the path (-1 = nobody), the last session
    // that won, and how many consecutive granted cycles went by without a
    // byte being taken. Values describe what the outputs show after an edge.
    int          m_owner    = -1;
    int          m_last_win = N - 1;
    int          m_streak   = 0;
    logic        m_vld      = 1'b0;
    logic [7:0]  m_msg      = '0;
    logic        m_last     = 1'b0;
    int          m_host     = 0;
    logic        m_abort    = 1'b0;
    int          m_abort_host = 0;

    task automatic model_step();
        int  o;
        int  c;
        bit  took;
        if (!rst) begin
            m_owner = -1; m_last_win = N - 1; m_streak = 0;
            m_vld = 1'b0; m_msg = '0; m_last = 1'b0; m_host = 0;
            m_abort = 1'b0; m_abort_host = 0;
        end else begin
            o = m_owner;
            m_vld = 1'b0;
            if (m_abort) begin
                m_abort = 1'b0;
            end else if (o < 0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last_win + k) % N;
                    if (m_owner < 0 && bus.req_i[c] && bus.connected_i[c]) begin
                        m_owner    = c;
                        m_last_win = c;
                        m_streak   = 0;
                    end
                end
            end else begin
                took = bus.byte_valid_i[o] && bus.tx_ready_i && bus.connected_i[o];
                if (took) begin
                    m_vld    = 1'b1;
                    m_msg    = bus.byte_i[o*DW +: DW];
                    m_last   = bus.eom_i[o];
                    m_host   = o;
                    m_streak = 0;
                    if (bus.eom_i[o]) m_owner = -1;
                end else begin
                    m_streak++;
                    if (!bus.connected_i[o] || m_streak >= SL) begin
                        m_abort      = 1'b1;
                        m_abort_host = o;
                        m_owner      = -1;
                        m_streak     = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rdy;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("cmp_rst_gnt", bus.gnt_o, 0);
                check("cmp_rst_vld", bus.send_message_valid_o, 0);
                check("cmp_rst_abort", bus.abort_o, 0);
            end else begin
                exp_gnt = '0;
                exp_rdy = '0;
                if (m_owner >= 0) begin
                    exp_gnt[m_owner] = 1'b1;
                    if (bus.byte_valid_i[m_owner] && bus.tx_ready_i && bus.connected_i[m_owner])
                        exp_rdy[m_owner] = 1'b1;
                end
                check("cmp_gnt", bus.gnt_o, exp_gnt);
                check("cmp_byte_ready", bus.byte_ready_o, exp_rdy);
                check("cmp_valid", bus.send_message_valid_o, m_vld);
                check("cmp_message", bus.message_o, m_msg);
                check("cmp_last", bus.message_last_o, m_last);
                check("cmp_host", bus.message_host_o, m_host);
                check("cmp_abort", bus.abort_o, m_abort);
                check("cmp_abort_host", bus.abort_host_o, m_abort_host);
            end
        end
    end

    logic [3:0] exp_seq [8];
    int         waited;
    int         seen_vld;

    initial begin
        rst              = 1'b0;
        bus.req_i        = '0;
        bus.connected_i  = '0;
        bus.byte_i       = '0;
        bus.byte_valid_i = '0;
        bus.eom_i        = '0;
        bus.tx_ready_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_gnt", bus.gnt_o, 0);
        check("reset_valid", bus.send_message_valid_o, 0);
        check("reset_msg", bus.message_o, 0);
        check("reset_abort", bus.abort_o, 0);
        rst = 1'b1;

        // Single session, message "ABC"; req drops after grant without effect
        bus.connected_i  = 4'b1111;
        bus.tx_ready_i   = 1'b1;
        bus.req_i        = 4'b0001;
        bus.byte_valid_i = 4'b0001;
        bus.byte_i[7:0]  = 8'h41;
        tick();
        check("t1_gnt", bus.gnt_o, 4'b0001);
        check("t1_rdy", bus.byte_ready_o, 4'b0001);
        check("t1_novld", bus.send_message_valid_o, 0);
        bus.req_i = '0;
        tick();
        check("t1_vld_a", bus.send_message_valid_o, 1);
        check("t1_msg_a", bus.message_o, 8'h41);
        check("t1_last_a", bus.message_last_o, 0);
        check("t1_host_a", bus.message_host_o, 0);
        bus.byte_i[7:0] = 8'h42;
        tick();
        check("t1_msg_b", bus.message_o, 8'h42);
        check("t1_last_b", bus.message_last_o, 0);
        bus.byte_i[7:0] = 8'h43;
        bus.eom_i       = 4'b0001;
        tick();
        check("t1_msg_c", bus.message_o, 8'h43);
        check("t1_last_c", bus.message_last_o, 1);
        check("t1_gnt_clr", bus.gnt_o, 0);
        bus.byte_valid_i = '0;
        bus.eom_i        = '0;
        tick();
        check("t1_vld_off", bus.send_message_valid_o, 0);
        check("t1_msg_hold", bus.message_o, 8'h43);

        // Round robin with one-byte messages
        bus.req_i        = 4'b1011;
        bus.byte_valid_i = 4'b1111;
        bus.eom_i        = 4'b1111;
        bus.byte_i       = 32'h44332211;
        exp_seq = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_gnt_seq", bus.gnt_o, exp_seq[i]);
        end
        bus.req_i        = '0;
        bus.byte_valid_i = '0;
        bus.eom_i        = '0;
        tick();

        // Stall watchdog on session 2
        bus.req_i        = 4'b0100;
        bus.byte_valid_i = 4'b0100;
        bus.tx_ready_i   = 1'b0;
        tick();
        check("t3_gnt", bus.gnt_o, 4'b0100);
        waited   = 0;
        seen_vld = 0;
        while (bus.abort_o !== 1'b1 && waited < 300) begin
            tick();
            waited++;
            if (bus.send_message_valid_o === 1'b1) seen_vld++;
        end
        check("t3_stall_cycles", waited, 256);
        check("t3_abort_host", bus.abort_host_o, 2);
        check("t3_gnt_clr", bus.gnt_o, 0);
        check("t3_no_vld", seen_vld, 0);
        bus.req_i = '0;
        tick();
        check("t3_abort_pulse", bus.abort_o, 0);
        check("t3_abort_host_hold", bus.abort_host_o, 2);
        bus.tx_ready_i   = 1'b1;
        bus.byte_valid_i = '0;
        tick();

        // Disconnect of session 1 after two of five bytes
        bus.req_i        = 4'b0010;
        bus.byte_valid_i = 4'b0010;
        bus.eom_i        = '0;
        tick();
        check("t4_gnt", bus.gnt_o, 4'b0010);
        bus.byte_i[15:8] = 8'h61;
        tick();
        check("t4_msg1", bus.message_o, 8'h61);
        bus.byte_i[15:8] = 8'h62;
        tick();
        check("t4_msg2", bus.message_o, 8'h62);
        check("t4_host", bus.message_host_o, 1);
        bus.connected_i = 4'b1101;
        #1;
        check("t4_rdy_drop", bus.byte_ready_o, 0);
        tick();
        check("t4_abort", bus.abort_o, 1);
        check("t4_abort_host", bus.abort_host_o, 1);
        check("t4_gnt_clr", bus.gnt_o, 0);
        check("t4_novld", bus.send_message_valid_o, 0);
        bus.connected_i  = 4'b1111;
        bus.req_i        = '0;
        bus.byte_valid_i = '0;
        tick();
        check("t4_abort_off", bus.abort_o, 0);

        // Unconnected requester is masked until it connects
        bus.req_i       = 4'b0100;
        bus.connected_i = 4'b1011;
        tick();
        tick();
        check("t5_masked", bus.gnt_o, 0);
        bus.connected_i = 4'b1111;
        tick();
        check("t5_gnt", bus.gnt_o, 4'b0100);
        bus.byte_valid_i = 4'b0100;
        bus.eom_i        = 4'b0100;
        bus.req_i        = '0;
        tick();
        check("t5_vld", bus.send_message_valid_o, 1);
        check("t5_host", bus.message_host_o, 2);
        check("t5_last", bus.message_last_o, 1);
        bus.byte_valid_i = '0;
        bus.eom_i        = '0;
        tick();

        // Asynchronous reset in the middle of a session 3 message
        bus.req_i        = 4'b1000;
        bus.byte_valid_i = 4'b1000;
        tick();
        check("t6_gnt", bus.gnt_o, 4'b1000);
        tick();
        check("t6_host", bus.message_host_o, 3);
        bus.req_i = 4'b1001;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_gnt", bus.gnt_o, 0);
        check("t6_rst_rdy", bus.byte_ready_o, 0);
        check("t6_rst_vld", bus.send_message_valid_o, 0);
        check("t6_rst_msg", bus.message_o, 0);
        check("t6_rst_last", bus.message_last_o, 0);
        check("t6_rst_host", bus.message_host_o, 0);
        check("t6_rst_abort", bus.abort_o, 0);
        check("t6_rst_abort_host", bus.abort_host_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("t6_s0_first", bus.gnt_o, 4'b0001);
        bus.byte_valid_i = 4'b1111;
        bus.eom_i        = 4'b1111;
        bus.req_i        = '0;
        tick();

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.req_i        = 4'($urandom);
            bus.byte_valid_i = 4'($urandom);
            bus.byte_i       = 32'($urandom);
            bus.eom_i        = 4'($urandom & $urandom);
            bus.tx_ready_i   = ($urandom_range(0, 3) != 0);
            bus.connected_i  = 4'b1111;
            if ($urandom_range(0, 15) == 0)
                bus.connected_i[$urandom_range(0, 3)] = 1'b0;
            tick();
        end

        bus.req_i        = '0;
        bus.byte_valid_i = '0;
        bus.eom_i        = '0;
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
